// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode and write-back stage: register ID decode, combinational operand
// reads and a dual-port write into the fifteen-entry register file, plus a sticky halt.
module decode_writeback #(
  parameter logic [63:0] RSP_INIT = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  icode,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic [7:0]  stat,
  input  logic        cnd,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic [3:0]  srcA,
  output logic [3:0]  srcB,
  output logic [3:0]  dstE,
  output logic [3:0]  dstM,
  output logic        halted,
  input  logic [3:0]  dbg_idx,
  output logic [63:0] dbg_val
);

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [7:0] SAOK  = 8'd1;

  typedef enum logic {RUN, STOP} state_t;

  state_t      state;
  logic [63:0] regs [0:14];
  logic        we;

  always_comb begin
    srcA = RNONE;
    srcB = RNONE;
    dstE = RNONE;
    dstM = RNONE;
    case (icode)
      4'h2: begin
        srcA = rA;
        if (cnd) dstE = rB;
      end
      4'h3: dstE = rB;
      4'h4: begin
        srcA = rA;
        srcB = rB;
      end
      4'h5: begin
        srcB = rB;
        dstM = rA;
      end
      4'h6: begin
        srcA = rA;
        srcB = rB;
        dstE = rB;
      end
      4'h8: begin
        srcB = RRSP;
        dstE = RRSP;
      end
      4'h9: begin
        srcA = RRSP;
        srcB = RRSP;
        dstE = RRSP;
      end
      4'hA: begin
        srcA = rA;
        srcB = RRSP;
        dstE = RRSP;
      end
      4'hB: begin
        srcA = RRSP;
        srcB = RRSP;
        dstE = RRSP;
        dstM = rA;
      end
      default: ;
    endcase
  end

  // Index F has no storage; it always reads as zero.
  always_comb begin
    valA    = (srcA == RNONE) ? 64'h0 : regs[srcA];
    valB    = (srcB == RNONE) ? 64'h0 : regs[srcB];
    dbg_val = (dbg_idx == RNONE) ? 64'h0 : regs[dbg_idx];
  end

  assign we     = (state == RUN) && (stat == SAOK);
  assign halted = (state == STOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else if (state == RUN && stat != SAOK) begin
      state <= STOP;
    end
  end

  // The dstM port is applied after dstE so memory data wins a collision (popq %rsp).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) begin
        regs[i] <= (i == 4) ? RSP_INIT : 64'h0;
      end
    end else if (we) begin
      for (int i = 0; i < 15; i++) begin
        if (dstE == 4'(i)) regs[i] <= valE;
        if (dstM == 4'(i)) regs[i] <= valM;
      end
    end
  end

endmodule
